// File: rtl/adder_operand_gen.sv
// adder_operand_gen: bounded LFSR operand stream {A,B,C0} for the adder units.
// Define CORNER_CASES_EN to prepend four fixed corner vectors to every run.
module adder_operand_gen #(
    parameter int unsigned      WIDTH       = 64,
    parameter logic [WIDTH-1:0] SEED_A      = WIDTH'(1),
    parameter logic [WIDTH-1:0] SEED_B      = WIDTH'(2),
    parameter int unsigned      NUM_VECTORS = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             C0,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             done,
    output logic [31:0]      vec_count
);

    localparam logic [WIDTH-1:0] TAPS =
        {5'b11011, {(WIDTH-5){1'b0}}};
    localparam logic [WIDTH-1:0] SA =
        (SEED_A == '0) ? WIDTH'(1) : SEED_A;
    localparam logic [WIDTH-1:0] SB =
        (SEED_B == '0) ? WIDTH'(1) : SEED_B;

`ifdef CORNER_CASES_EN
    localparam int unsigned NCORNER = 4;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] P55 =
        WIDTH'({WIDTH{2'b01}});
    localparam logic [WIDTH-1:0] PAA = ~P55;

    typedef enum logic [1:0] {
        IDLE, CORNER, RUN, DONE
    } state_t;

    function automatic logic [2*WIDTH:0] corner_vec(
        input logic [1:0] i
    );
        unique case (i)
            2'd0:    corner_vec = {ZERO, ZERO, 1'b0};
            2'd1:    corner_vec = {ONES, ZERO, 1'b1};
            2'd2:    corner_vec = {ONES, ONES, 1'b1};
            default: corner_vec = {P55, PAA, 1'b0};
        endcase
    endfunction

    logic [1:0] idx_q, idx_d;
`else
    localparam int unsigned NCORNER = 0;

    typedef enum logic [1:0] {
        IDLE, RUN, DONE
    } state_t;
`endif

    localparam logic [31:0] LAST =
        32'(NUM_VECTORS + NCORNER - 1);

    function automatic logic [WIDTH-1:0] step(
        input logic [WIDTH-1:0] s
    );
        step = (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_a, lfsr_b;
    logic [WIDTH-1:0] la_d, lb_d;
    logic [WIDTH-1:0] step_a, step_b;
    logic [WIDTH-1:0] a_d, b_d;
    logic             c0_d, valid_d, accept;
    logic [31:0]      cnt_d;

    always_comb begin
        state_d = state_q;
        a_d     = A;
        b_d     = B;
        c0_d    = C0;
        valid_d = valid;
        cnt_d   = vec_count;
        la_d    = lfsr_a;
        lb_d    = lfsr_b;
`ifdef CORNER_CASES_EN
        idx_d   = idx_q;
`endif
        step_a  = step(lfsr_a);
        step_b  = step(lfsr_b);
        accept  = valid && ready;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cnt_d   = '0;
                    la_d    = SA;
                    lb_d    = SB;
                    valid_d = 1'b1;
`ifdef CORNER_CASES_EN
                    state_d = CORNER;
                    idx_d   = 2'd0;
                    {a_d, b_d, c0_d} = corner_vec(2'd0);
`else
                    state_d = RUN;
                    a_d     = SA;
                    b_d     = SB;
                    c0_d    = SA[0] ^ SB[0];
`endif
                end
            end
`ifdef CORNER_CASES_EN
            CORNER: begin
                // LFSRs hold their seeds until the corner list is exhausted
                if (accept) begin
                    cnt_d = vec_count + 32'd1;
                    if (idx_q == 2'd3) begin
                        state_d = RUN;
                        a_d     = lfsr_a;
                        b_d     = lfsr_b;
                        c0_d    = lfsr_a[0] ^ lfsr_b[0];
                    end else begin
                        idx_d = idx_q + 2'd1;
                        {a_d, b_d, c0_d} = corner_vec(idx_q + 2'd1);
                    end
                end
            end
`endif
            RUN: begin
                if (accept) begin
                    cnt_d = vec_count + 32'd1;
                    la_d  = step_a;
                    lb_d  = step_b;
                    if (vec_count == LAST) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                    end else begin
                        a_d  = step_a;
                        b_d  = step_b;
                        c0_d = step_a[0] ^ step_b[0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            A         <= '0;
            B         <= '0;
            C0        <= 1'b0;
            valid     <= 1'b0;
            vec_count <= '0;
            lfsr_a    <= SA;
            lfsr_b    <= SB;
`ifdef CORNER_CASES_EN
            idx_q     <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            A         <= a_d;
            B         <= b_d;
            C0        <= c0_d;
            valid     <= valid_d;
            vec_count <= cnt_d;
            lfsr_a    <= la_d;
            lfsr_b    <= lb_d;
`ifdef CORNER_CASES_EN
            idx_q     <= idx_d;
`endif
        end
    end

`ifdef CORNER_CASES_EN
    assign busy = (state_q == CORNER) || (state_q == RUN);
`else
    assign busy = (state_q == RUN);
`endif
    assign done = (state_q == DONE);

endmodule
